run_stream_tx: RTL and testbench
================================

RUN_STREAM_TX -- requirements
Module: run_stream_tx

Interface
REQ-001 Parameter: LEN_W, default 4, width of the run-length field (max run 2^LEN_W-1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_bit  input  1  bit value of the run.
REQ-006 cmd_len  input  LEN_W  number of bits in the run; 0 legal.
REQ-007 cmd_ready  output  1  command buffer can accept; transfer on cmd_valid&&cmd_ready at a rising edge.
REQ-008 clr_count  input  1  synchronous clear of run3_count.
REQ-009 out  output  1  serial bit; 0 whenever out_valid=0.
REQ-010 out_valid  output  1  out carries a stream bit this cycle.
REQ-011 busy  output  1  high when in SEND or buffer non-empty.
REQ-012 run3_count  output  8  count of emitted bits that complete a run of three consecutive 1s, overlapping.

Function
REQ-013 The block SHALL hold a 2-entry FIFO of {cmd_bit, cmd_len}; cmd_ready = FIFO not full, combinational from FIFO occupancy only.
REQ-014 A pop SHALL see only entries written on earlier edges; a push and a pop on the same edge are both honoured.
REQ-015 FSM states SHALL be IDLE and SEND; out, out_valid, and the remaining-bit counter rem are registered.
REQ-016 IDLE, FIFO empty: out_valid=0, out=0, state held.
REQ-017 IDLE, FIFO non-empty, head len>=1: pop; out<=bit, out_valid<=1, rem<=len-1, go SEND.
REQ-018 IDLE, FIFO non-empty, head len=0: pop and discard; no output; stay IDLE.
REQ-019 SEND, rem>0: out<=current bit, out_valid<=1, rem<=rem-1.
REQ-020 SEND, rem=0, head len>=1: pop and emit its first bit on the next cycle with no gap, as in REQ-017.
REQ-021 SEND, rem=0, FIFO empty or head len=0: out_valid<=0, out<=0, go IDLE; a len=0 head is popped and discarded.
REQ-022 Latency: first bit of a command accepted at edge k into an empty, idle block SHALL be driven after edge k+1.
REQ-023 A command of length N SHALL produce exactly N consecutive out_valid cycles.
REQ-024 Run tracking: keep a 2-bit history of the last two valid output bits; the history is cleared by any cycle with out_valid=0.
REQ-025 run3_count SHALL increment at the edge following a cycle with out_valid=1, out=1, and both history bits 1.
REQ-026 run3_count SHALL saturate at 255.
REQ-027 If clr_count and an increment coincide, clear wins and the result is 0.

Reset
REQ-028 When reset_n=0: state=IDLE, FIFO empty, rem=0, history=0, out=0, out_valid=0, busy=0, run3_count=0, and cmd_ready=1.
REQ-029 All values in REQ-028 SHALL apply immediately, independent of clk.
REQ-030 Reset mid-run SHALL abort the current run and discard buffered commands.
REQ-031 The first pop after reset_n deasserts SHALL occur no earlier than the second rising edge after deassertion.

Verification
REQ-032 Reset: assert reset_n=0 -> out=0, out_valid=0, busy=0, run3_count=0, cmd_ready=1.
REQ-033 Single command (1,5) accepted at edge k -> out=1 with out_valid=1 for the 5 cycles after edges k+1..k+5, then out_valid=0; run3_count=3.
REQ-034 Back-to-back (1,2) then (1,2) on consecutive edges -> 4 gapless 1-bits; run3_count=2.
REQ-035 Sequence (1,2), (0,1), (1,2) -> output 11011; run3_count=0.
REQ-036 Push (0,15), then 3 more commands held valid -> cmd_ready=0 once 2 are buffered; the third transfers the edge after the first pop frees an entry.
REQ-037 Len-0 command (1,0) -> no out_valid cycles, busy returns to 0; then reset_n=0 mid (1,7) -> out_valid=0 immediately and the queued (1,3) is never emitted.

Source files
------------

// File: rtl/run_stream_tx.sv
// Serialises {bit, len} run commands from a 2-entry buffer onto a one-bit stream
// and counts emitted bits that complete a run of three consecutive 1s.
module run_stream_tx #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic             cmd_bit,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             clr_count,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic [7:0]       run3_count
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic             fifo_bit_q [2];
  logic [LEN_W-1:0] fifo_len_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             push, pop, fifo_empty;
  logic             head_bit;
  logic [LEN_W-1:0] head_len;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             cur_bit_q, cur_bit_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       hist_q;
  logic [7:0]       run3_q;

  assign fifo_empty = (count_q == 2'd0);
  assign cmd_ready  = (count_q != 2'd2);
  assign push       = cmd_valid & cmd_ready;
  assign head_bit   = fifo_bit_q[rd_ptr_q];
  assign head_len   = fifo_len_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_bit_q[i] <= 1'b0;
        fifo_len_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_bit_q[wr_ptr_q] <= cmd_bit;
        fifo_len_q[wr_ptr_q] <= cmd_len;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A pop only ever looks at the registered head, so same-edge pushes are never seen.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cur_bit_d   = cur_bit_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      SEND: begin
        if (rem_q != '0) begin
          out_d       = cur_bit_q;
          out_valid_d = 1'b1;
          rem_d       = rem_q - LEN_W'(1);
        end else begin
          pop     = !fifo_empty;
          state_d = IDLE;
        end
      end
      default: pop = !fifo_empty;
    endcase
    // Zero-length heads are popped with no output, leaving the FSM in IDLE.
    if (pop && head_len != '0) begin
      out_d       = head_bit;
      out_valid_d = 1'b1;
      cur_bit_d   = head_bit;
      rem_d       = head_len - LEN_W'(1);
      state_d     = SEND;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      cur_bit_q   <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      hist_q      <= 2'b00;
      run3_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cur_bit_q   <= cur_bit_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      hist_q      <= out_valid_q ? {hist_q[0], out_q} : 2'b00;
      if (clr_count)
        run3_q <= 8'd0;
      else if (out_valid_q && out_q && hist_q == 2'b11 && run3_q != 8'hFF)
        run3_q <= run3_q + 8'd1;
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q == SEND) || !fifo_empty;
  assign run3_count = run3_q;

endmodule

// File: tb/tb_run_stream_tx.sv
// Bench for run_stream_tx: a cycle model built from a queue of pending runs and a
// count of consecutive 1s, plus a vector table and directed corner-case sequences.
module tb_run_stream_tx;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_bit = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             clr_count = 1'b0;
  logic             cmd_ready, out, out_valid, busy;
  logic [7:0]       run3_count;

  run_stream_tx #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_bit(cmd_bit),
    .cmd_len(cmd_len), .cmd_ready(cmd_ready), .clr_count(clr_count), .out(out),
    .out_valid(out_valid), .busy(busy), .run3_count(run3_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic b; logic [LEN_W-1:0] len;} cmd_t;
  typedef struct packed {logic b; logic [LEN_W-1:0] len; int n; int r;} vec_t;

  int n_checks = 0;
  int n_pass = 0;

  // reference model
  cmd_t m_q[$];
  int   m_rem, m_ones, m_run3;
  logic m_bit, m_out, m_valid;

  // observation
  cmd_t pend[$];
  logic obs[$];
  int   xfer_edges[$];
  int   edge_no, first_v, last_v;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  function automatic int xe(int i);
    return (i < xfer_edges.size()) ? xfer_edges[i] : -1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rem = 0; m_ones = 0; m_run3 = 0;
    m_bit = 0; m_out = 0; m_valid = 0;
  endtask

  task automatic clear_obs();
    obs.delete();
    xfer_edges.delete();
    edge_no = 0; first_v = -1; last_v = -1;
  endtask

  task automatic model_step();
    bit   rdy;
    cmd_t h;
    rdy = (m_q.size() < 2);
    if (m_valid && m_out) m_ones++;
    else m_ones = 0;
    if (clr_count) m_run3 = 0;
    else if (m_valid && m_out && m_ones >= 3 && m_run3 < 255) m_run3++;
    if (m_rem > 0) begin
      m_out = m_bit; m_valid = 1; m_rem--;
    end else if (m_q.size() > 0) begin
      h = m_q.pop_front();
      if (h.len != 0) begin
        m_bit = h.b; m_out = h.b; m_valid = 1; m_rem = int'(h.len) - 1;
      end else begin
        m_out = 0; m_valid = 0;
      end
    end else begin
      m_out = 0; m_valid = 0;
    end
    if (cmd_valid && rdy) m_q.push_back('{b: cmd_bit, len: cmd_len});
  endtask

  task automatic tick();
    bit dx;
    dx = cmd_valid && cmd_ready;
    @(posedge clk);
    model_step();
    edge_no++;
    if (dx) xfer_edges.push_back(edge_no);
    #1;
    if (out_valid) begin
      obs.push_back(out);
      if (first_v < 0) first_v = edge_no;
      last_v = edge_no;
    end
    check("out", int'(out), int'(m_out));
    check("out_valid", int'(out_valid), int'(m_valid));
    check("cmd_ready", int'(cmd_ready), int'(m_q.size() < 2));
    check("busy", int'(busy), int'(m_valid || m_q.size() > 0));
    check("run3_count", int'(run3_count), m_run3);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 0; cmd_valid = 0; clr_count = 0;
    model_reset();
    #1;
    check("rst_out", int'(out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_run3", int'(run3_count), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1;
    clear_obs();
  endtask

  task automatic feed_one();
    bit mx;
    if (pend.size() > 0) begin
      cmd_valid = 1; cmd_bit = pend[0].b; cmd_len = pend[0].len;
    end else begin
      cmd_valid = 0;
    end
    mx = cmd_valid && (m_q.size() < 2);
    tick();
    if (mx) void'(pend.pop_front());
    cmd_valid = 0;
  endtask

  task automatic run_seq(string name, int max_cycles);
    int c;
    c = 0;
    while ((pend.size() > 0 || m_valid || m_q.size() > 0) && c < max_cycles) begin
      feed_one();
      c++;
    end
    check({name, "_timeout"}, int'(c >= max_cycles), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   k, v;
    tbl[0] = '{b: 1'b1, len: 4'd5,  n: 5,  r: 3};
    tbl[1] = '{b: 1'b1, len: 4'd0,  n: 0,  r: 0};
    tbl[2] = '{b: 1'b0, len: 4'd15, n: 15, r: 0};
    tbl[3] = '{b: 1'b1, len: 4'd15, n: 15, r: 13};
    tbl[4] = '{b: 1'b1, len: 4'd1,  n: 1,  r: 0};
    tbl[5] = '{b: 1'b1, len: 4'd3,  n: 3,  r: 1};
    tbl[6] = '{b: 1'b0, len: 4'd7,  n: 7,  r: 0};
    tbl[7] = '{b: 1'b1, len: 4'd4,  n: 4,  r: 2};

    model_reset();
    clear_obs();

    for (int i = 0; i < 8; i++) begin
      do_reset();
      pend.push_back('{b: tbl[i].b, len: tbl[i].len});
      run_seq($sformatf("tbl%0d", i), 100);
      check($sformatf("tbl%0d_cycles", i), obs.size(), tbl[i].n);
      check($sformatf("tbl%0d_run3", i), int'(run3_count), tbl[i].r);
      k = 0;
      foreach (obs[j]) if (obs[j] == tbl[i].b) k++;
      check($sformatf("tbl%0d_bits", i), k, tbl[i].n);
    end

    // single (1,5): latency and run count
    do_reset();
    pend.push_back('{b: 1'b1, len: 4'd5});
    run_seq("single", 100);
    check("single_xfer_edge", xe(0), 1);
    check("single_first_valid", first_v, 2);
    check("single_last_valid", last_v, 6);
    check("single_run3", int'(run3_count), 3);

    // back-to-back (1,2),(1,2)
    do_reset();
    pend.push_back('{b: 1'b1, len: 4'd2});
    pend.push_back('{b: 1'b1, len: 4'd2});
    run_seq("b2b", 100);
    check("b2b_xfer1", xe(1), 2);
    check("b2b_count", obs.size(), 4);
    check("b2b_gapless", last_v - first_v + 1, 4);
    check("b2b_run3", int'(run3_count), 2);

    // 11011 pattern
    do_reset();
    pend.push_back('{b: 1'b1, len: 4'd2});
    pend.push_back('{b: 1'b0, len: 4'd1});
    pend.push_back('{b: 1'b1, len: 4'd2});
    run_seq("pat", 100);
    v = 0;
    foreach (obs[j]) v = (v << 1) | int'(obs[j]);
    check("pat_len", obs.size(), 5);
    check("pat_bits", v, 27);
    check("pat_gapless", last_v - first_v + 1, 5);
    check("pat_run3", int'(run3_count), 0);

    // backpressure behind a long (0,15)
    do_reset();
    pend.push_back('{b: 1'b0, len: 4'd15});
    pend.push_back('{b: 1'b1, len: 4'd1});
    pend.push_back('{b: 1'b0, len: 4'd2});
    pend.push_back('{b: 1'b1, len: 4'd3});
    run_seq("bp", 200);
    check("bp_xfer0", xe(0), 1);
    check("bp_xfer1", xe(1), 2);
    check("bp_xfer2", xe(2), 3);
    check("bp_xfer3", xe(3), 18);
    check("bp_count", obs.size(), 21);
    check("bp_run3", int'(run3_count), 1);

    // zero-length command, then reset in the middle of a run
    do_reset();
    pend.push_back('{b: 1'b1, len: 4'd0});
    run_seq("len0", 50);
    check("len0_count", obs.size(), 0);
    check("len0_busy", int'(busy), 0);
    pend.push_back('{b: 1'b1, len: 4'd7});
    pend.push_back('{b: 1'b1, len: 4'd3});
    repeat (4) feed_one();
    check("midrst_pre_valid", int'(out_valid), 1);
    pend.delete();
    do_reset();
    repeat (20) tick();
    check("midrst_no_emit", obs.size(), 0);

    // saturation at 255
    do_reset();
    repeat (20) pend.push_back('{b: 1'b1, len: 4'd15});
    run_seq("sat", 1000);
    check("sat_count", obs.size(), 300);
    check("sat_gapless", last_v - first_v + 1, 300);
    check("sat_run3", int'(run3_count), 255);

    // clear coinciding with an increment
    do_reset();
    pend.push_back('{b: 1'b1, len: 4'd10});
    repeat (7) feed_one();
    check("clr_pre", int'(run3_count), 3);
    clr_count = 1;
    feed_one();
    clr_count = 0;
    check("clr_wins", int'(run3_count), 0);
    feed_one();
    check("clr_resume", int'(run3_count), 1);
    run_seq("clr", 100);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_bit   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) cmd_len = '0;
      else if ($urandom_range(0, 9) == 0) cmd_len = 4'd15;
      else cmd_len = LEN_W'($urandom_range(1, 5));
      clr_count = ($urandom_range(0, 63) == 0);
      tick();
    end
    cmd_valid = 0;
    clr_count = 0;
    run_seq("rand_drain", 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
